// File: rtl/param_data_loader.sv
// rtl/param_data_loader.sv - FM/weight RAM loader with INIT and ping-pong UPDATE operations
module param_data_loader #(
  parameter int DATA_WIDTH      = 16,
  parameter int PARA_X          = 3,
  parameter int PARA_Y          = 3,
  parameter int PARA_KERNEL     = 8,
  parameter int KERNEL_SIZE_MAX = 5,
  parameter int FM_ADDR_WIDTH   = 10,
  parameter int W_ADDR_WIDTH    = 10,
  parameter int LEN_WIDTH       = 8,
  localparam int FM_WORD_W      = PARA_X * PARA_Y * DATA_WIDTH,
  localparam int W_WORD_W       = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX * PARA_KERNEL * DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init,
  input  logic                     upd_req,
  input  logic                     upd_bank,
  input  logic [LEN_WIDTH-1:0]     fm_len,
  input  logic [LEN_WIDTH-1:0]     w_len,
  input  logic [FM_WORD_W-1:0]     fm_src_data,
  input  logic                     fm_src_valid,
  output logic                     fm_src_ready,
  input  logic [W_WORD_W-1:0]      w_src_data,
  input  logic                     w_src_valid,
  output logic                     w_src_ready,
  output logic                     fm_wr_en,
  output logic [FM_ADDR_WIDTH-1:0] fm_wr_addr,
  output logic [FM_WORD_W-1:0]     fm_wr_data,
  output logic                     w_wr_en,
  output logic [W_ADDR_WIDTH-1:0]  w_wr_addr,
  output logic [W_WORD_W-1:0]      w_wr_data,
  output logic                     init_fm_data_done,
  output logic                     weight_data_done,
  output logic                     busy,
  output logic                     req_drop
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_FM = 2'd1,
    LOAD_W  = 2'd2
  } state_t;

  localparam logic [W_ADDR_WIDTH-1:0]  W_STRIDE    = W_ADDR_WIDTH'(KERNEL_SIZE_MAX * KERNEL_SIZE_MAX);
  localparam logic [W_ADDR_WIDTH-1:0]  W_HALF_BASE = W_ADDR_WIDTH'(1) << (W_ADDR_WIDTH - 1);
  localparam logic [FM_ADDR_WIDTH-1:0] FM_ONE      = FM_ADDR_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]     LEN_ONE     = LEN_WIDTH'(1);

  state_t                   state, state_next;
  logic [LEN_WIDTH-1:0]     fm_len_q, w_len_q, beat_cnt;
  logic [FM_ADDR_WIDTH-1:0] fm_addr_q;
  logic [W_ADDR_WIDTH-1:0]  w_addr_q;
  logic                     fm_end_q, w_end_q;
  logic                     start_init, start_upd;
  logic                     fm_fire, w_fire, fm_end, w_end;

  // A zero-length phase never raises ready, so a source holding valid loses no word.
  assign fm_src_ready = (state == LOAD_FM) && (fm_len_q != '0);
  assign w_src_ready  = (state == LOAD_W) && (w_len_q != '0);
  assign busy         = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state decode, start detection and per-phase beat/end strobes.
  always_comb begin
    state_next = state;
    start_init = 1'b0;
    start_upd  = 1'b0;
    fm_fire    = 1'b0;
    w_fire     = 1'b0;
    fm_end     = 1'b0;
    w_end      = 1'b0;
    case (state)
      IDLE: begin
        if (init) begin
          start_init = 1'b1;
          state_next = LOAD_FM;
        end else if (upd_req) begin
          start_upd  = 1'b1;
          state_next = LOAD_W;
        end
      end
      LOAD_FM: begin
        fm_fire = fm_src_valid && (fm_len_q != '0);
        fm_end  = (fm_len_q == '0) || (fm_fire && (beat_cnt == fm_len_q - LEN_ONE));
        if (fm_end) state_next = LOAD_W;
      end
      LOAD_W: begin
        w_fire = w_src_valid && (w_len_q != '0);
        w_end  = (w_len_q == '0) || (w_fire && (beat_cnt == w_len_q - LEN_ONE));
        if (w_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Length latches, address counters, registered RAM writes and done/drop flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fm_len_q          <= '0;
      w_len_q           <= '0;
      beat_cnt          <= '0;
      fm_addr_q         <= '0;
      w_addr_q          <= '0;
      fm_end_q          <= 1'b0;
      w_end_q           <= 1'b0;
      fm_wr_en          <= 1'b0;
      fm_wr_addr        <= '0;
      fm_wr_data        <= '0;
      w_wr_en           <= 1'b0;
      w_wr_addr         <= '0;
      w_wr_data         <= '0;
      init_fm_data_done <= 1'b0;
      weight_data_done  <= 1'b0;
      req_drop          <= 1'b0;
    end else begin
      fm_wr_en <= 1'b0;
      w_wr_en  <= 1'b0;
      fm_end_q <= fm_end;
      w_end_q  <= w_end;
      // Both requests in IDLE: init is served and upd_req is the one dropped.
      req_drop <= (state == IDLE) ? (init && upd_req) : (init || upd_req);
      // Done lags the phase end by two cycles so it rises after the last write lands.
      if (fm_end_q) init_fm_data_done <= 1'b1;
      if (w_end_q)  weight_data_done  <= 1'b1;
      if (start_init) begin
        fm_len_q          <= fm_len;
        w_len_q           <= w_len;
        beat_cnt          <= '0;
        fm_addr_q         <= '0;
        w_addr_q          <= '0;
        init_fm_data_done <= 1'b0;
        weight_data_done  <= 1'b0;
      end else if (start_upd) begin
        w_len_q          <= w_len;
        beat_cnt         <= '0;
        w_addr_q         <= upd_bank ? W_HALF_BASE : '0;
        weight_data_done <= 1'b0;
      end
      if (fm_fire) begin
        fm_wr_en   <= 1'b1;
        fm_wr_addr <= fm_addr_q;
        fm_wr_data <= fm_src_data;
        fm_addr_q  <= fm_addr_q + FM_ONE;
        beat_cnt   <= beat_cnt + LEN_ONE;
      end
      if (w_fire) begin
        w_wr_en   <= 1'b1;
        w_wr_addr <= w_addr_q;
        w_wr_data <= w_src_data;
        w_addr_q  <= w_addr_q + W_STRIDE;
        beat_cnt  <= beat_cnt + LEN_ONE;
      end
      if (fm_end || w_end) beat_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_param_data_loader.sv
// tb/tb_param_data_loader.sv - scoreboard bench for param_data_loader
module tb_param_data_loader;

  localparam int FMW = 3 * 3 * 16;
  localparam int WW  = 5 * 5 * 8 * 16;

  typedef struct {
    logic [9:0]     addr;
    logic [FMW-1:0] data;
    int             cyc;
  } fm_exp_t;

  typedef struct {
    logic [9:0]    addr;
    logic [WW-1:0] data;
    int            cyc;
  } w_exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           init = 1'b0;
  logic           upd_req = 1'b0;
  logic           upd_bank = 1'b0;
  logic [7:0]     fm_len = '0;
  logic [7:0]     w_len = '0;
  logic [FMW-1:0] fm_src_data = '0;
  logic           fm_src_valid = 1'b0;
  logic           fm_src_ready;
  logic [WW-1:0]  w_src_data = '0;
  logic           w_src_valid = 1'b0;
  logic           w_src_ready;
  logic           fm_wr_en;
  logic [9:0]     fm_wr_addr;
  logic [FMW-1:0] fm_wr_data;
  logic           w_wr_en;
  logic [9:0]     w_wr_addr;
  logic [WW-1:0]  w_wr_data;
  logic           init_fm_data_done;
  logic           weight_data_done;
  logic           busy;
  logic           req_drop;

  fm_exp_t fm_q[$];
  w_exp_t  w_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_fm_wr = 0;
  int n_w_wr = 0;

  param_data_loader dut (
    .clk               (clk),
    .rst               (rst),
    .init              (init),
    .upd_req           (upd_req),
    .upd_bank          (upd_bank),
    .fm_len            (fm_len),
    .w_len             (w_len),
    .fm_src_data       (fm_src_data),
    .fm_src_valid      (fm_src_valid),
    .fm_src_ready      (fm_src_ready),
    .w_src_data        (w_src_data),
    .w_src_valid       (w_src_valid),
    .w_src_ready       (w_src_ready),
    .fm_wr_en          (fm_wr_en),
    .fm_wr_addr        (fm_wr_addr),
    .fm_wr_data        (fm_wr_data),
    .w_wr_en           (w_wr_en),
    .w_wr_addr         (w_wr_addr),
    .w_wr_data         (w_wr_data),
    .init_fm_data_done (init_fm_data_done),
    .weight_data_done  (weight_data_done),
    .busy              (busy),
    .req_drop          (req_drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon_fm
    fm_exp_t e;
    if (fm_wr_en === 1'b1) begin
      n_fm_wr = n_fm_wr + 1;
      n_cmp = n_cmp + 1;
      if (fm_q.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL fm_write_unexpected: got addr=%0d, required no write", fm_wr_addr);
      end else begin
        e = fm_q.pop_front();
        if (fm_wr_addr !== e.addr || fm_wr_data !== e.data || cyc != e.cyc) begin
          n_err = n_err + 1;
          $display("FAIL fm_write: got addr=%0d data_lo=%h cyc=%0d, required addr=%0d data_lo=%h cyc=%0d",
                   fm_wr_addr, fm_wr_data[31:0], cyc, e.addr, e.data[31:0], e.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_w
    w_exp_t e;
    if (w_wr_en === 1'b1) begin
      n_w_wr = n_w_wr + 1;
      n_cmp = n_cmp + 1;
      if (w_q.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL w_write_unexpected: got addr=%0d, required no write", w_wr_addr);
      end else begin
        e = w_q.pop_front();
        if (w_wr_addr !== e.addr || w_wr_data !== e.data || cyc != e.cyc) begin
          n_err = n_err + 1;
          $display("FAIL w_write: got addr=%0d data_lo=%h cyc=%0d, required addr=%0d data_lo=%h cyc=%0d",
                   w_wr_addr, w_wr_data[31:0], cyc, e.addr, e.data[31:0], e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic start_init(input int fl, input int wl);
    fm_len = 8'(fl);
    w_len  = 8'(wl);
    init   = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
  endtask

  task automatic start_update(input bit bank, input int wl);
    w_len    = 8'(wl);
    upd_bank = bank;
    upd_req  = 1'b1;
    @(posedge clk); #1;
    upd_req = 1'b0;
  endtask

  // Offers n FM beats; gappy gives the 1,0,0,1 valid pattern.
  task automatic feed_fm(input int n, input bit gappy);
    logic [FMW-1:0] d;
    fm_exp_t e;
    int waited;
    bit acc;
    for (int k = 0; k < n; k++) begin
      if (gappy && (k % 2 == 1)) repeat (2) begin @(posedge clk); #1; end
      for (int i = 0; i < FMW / 16; i++) d[i*16 +: 16] = 16'($urandom);
      fm_src_data  = d;
      fm_src_valid = 1'b1;
      acc = 1'b0;
      waited = 0;
      while (!acc && waited < 200) begin
        @(negedge clk);
        if (fm_src_ready === 1'b1) begin
          e.addr = 10'(k);
          e.data = d;
          e.cyc  = cyc + 1;
          fm_q.push_back(e);
          acc = 1'b1;
        end
        @(posedge clk); #1;
        waited++;
      end
      fm_src_valid = 1'b0;
      if (!acc) begin
        n_cmp = n_cmp + 1;
        n_err = n_err + 1;
        $display("FAIL fm_src_ready_timeout: beat %0d never accepted", k);
        return;
      end
    end
  endtask

  task automatic feed_w(input int n, input int base, input bit gappy);
    logic [WW-1:0] d;
    w_exp_t e;
    int waited;
    bit acc;
    for (int k = 0; k < n; k++) begin
      if (gappy && (k % 2 == 1)) repeat (2) begin @(posedge clk); #1; end
      for (int i = 0; i < WW / 32; i++) d[i*32 +: 32] = $urandom;
      w_src_data  = d;
      w_src_valid = 1'b1;
      acc = 1'b0;
      waited = 0;
      while (!acc && waited < 200) begin
        @(negedge clk);
        if (w_src_ready === 1'b1) begin
          e.addr = 10'((base + k * 25) % 1024);
          e.data = d;
          e.cyc  = cyc + 1;
          w_q.push_back(e);
          acc = 1'b1;
        end
        @(posedge clk); #1;
        waited++;
      end
      w_src_valid = 1'b0;
      if (!acc) begin
        n_cmp = n_cmp + 1;
        n_err = n_err + 1;
        $display("FAIL w_src_ready_timeout: beat %0d never accepted", k);
        return;
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      n_cmp = n_cmp + 1;
      n_err = n_err + 1;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp = n_cmp + 1;
    if ({fm_wr_en, w_wr_en, fm_src_ready, w_src_ready, init_fm_data_done,
         weight_data_done, busy, req_drop} !== 8'b0) begin
      n_err = n_err + 1;
      $display("FAIL reset_flags: got %b, required 00000000",
               {fm_wr_en, w_wr_en, fm_src_ready, w_src_ready, init_fm_data_done,
                weight_data_done, busy, req_drop});
    end
    n_cmp = n_cmp + 1;
    if (fm_wr_addr !== 10'd0 || w_wr_addr !== 10'd0 || fm_wr_data !== '0 || w_wr_data !== '0) begin
      n_err = n_err + 1;
      $display("FAIL reset_addr_data: got fm_addr=%0d w_addr=%0d, required 0/0 and zero data",
               fm_wr_addr, w_wr_addr);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_init();
    int fm0 = n_fm_wr;
    int w0  = n_w_wr;
    start_init(18, 4);
    feed_fm(18, 1'b0);
    feed_w(4, 0, 1'b0);
    @(negedge clk);
    n_cmp = n_cmp + 1;
    if (weight_data_done !== 1'b0 || busy !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL init_done_early: got w_done=%b busy=%b, required 0/0", weight_data_done, busy);
    end
    @(negedge clk);
    n_cmp = n_cmp + 1;
    if (weight_data_done !== 1'b1 || init_fm_data_done !== 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL init_done: got fm_done=%b w_done=%b, required 1/1", init_fm_data_done, weight_data_done);
    end
    n_cmp = n_cmp + 1;
    if (n_fm_wr - fm0 != 18 || n_w_wr - w0 != 4 || fm_q.size() != 0 || w_q.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL init_write_count: got fm=%0d w=%0d, required 18/4", n_fm_wr - fm0, n_w_wr - w0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_update();
    start_update(1'b1, 4);
    @(negedge clk);
    n_cmp = n_cmp + 1;
    if (weight_data_done !== 1'b0 || init_fm_data_done !== 1'b1 || w_src_ready !== 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL update_start: got w_done=%b fm_done=%b w_ready=%b, required 0/1/1",
               weight_data_done, init_fm_data_done, w_src_ready);
    end
    @(posedge clk); #1;
    feed_w(4, 512, 1'b0);
    wait_idle();
    n_cmp = n_cmp + 1;
    if (weight_data_done !== 1'b1 || init_fm_data_done !== 1'b1 || w_q.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL update_done: got w_done=%b fm_done=%b pending=%0d, required 1/1/0",
               weight_data_done, init_fm_data_done, w_q.size());
    end
  endtask

  task automatic test_gaps();
    int fm0 = n_fm_wr;
    start_init(7, 3);
    feed_fm(7, 1'b1);
    feed_w(3, 0, 1'b1);
    wait_idle();
    n_cmp = n_cmp + 1;
    if (n_fm_wr - fm0 != 7 || fm_q.size() != 0 || w_q.size() != 0 || weight_data_done !== 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL gaps_count: got fm=%0d pending=%0d/%0d w_done=%b, required 7, 0/0, 1",
               n_fm_wr - fm0, fm_q.size(), w_q.size(), weight_data_done);
    end
  endtask

  task automatic test_collision();
    fm_len   = 8'd2;
    w_len    = 8'd2;
    upd_bank = 1'b1;
    init     = 1'b1;
    upd_req  = 1'b1;
    @(posedge clk); #1;
    init    = 1'b0;
    upd_req = 1'b0;
    @(negedge clk);
    n_cmp = n_cmp + 1;
    if (req_drop !== 1'b1 || fm_src_ready !== 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL collision_drop: got req_drop=%b fm_ready=%b, required 1/1", req_drop, fm_src_ready);
    end
    @(negedge clk);
    n_cmp = n_cmp + 1;
    if (req_drop !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL collision_drop_pulse: got req_drop=%b, required 0", req_drop);
    end
    @(posedge clk); #1;
    feed_fm(2, 1'b0);
    upd_req = 1'b1;
    @(posedge clk); #1;
    upd_req = 1'b0;
    @(negedge clk);
    n_cmp = n_cmp + 1;
    if (req_drop !== 1'b1 || w_src_ready !== 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL busy_drop: got req_drop=%b w_ready=%b, required 1/1", req_drop, w_src_ready);
    end
    @(posedge clk); #1;
    feed_w(2, 0, 1'b0);
    wait_idle();
    n_cmp = n_cmp + 1;
    if (fm_q.size() != 0 || w_q.size() != 0 || busy !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL collision_end: got pending=%0d/%0d busy=%b, required 0/0/0",
               fm_q.size(), w_q.size(), busy);
    end
  endtask

  task automatic test_zero_fm();
    int fm0 = n_fm_wr;
    fm_src_valid = 1'b1;
    start_init(0, 2);
    @(negedge clk);
    n_cmp = n_cmp + 1;
    if (fm_src_ready !== 1'b0 || busy !== 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL zero_fm_ready: got fm_ready=%b busy=%b, required 0/1", fm_src_ready, busy);
    end
    @(posedge clk); #1;
    fm_src_valid = 1'b0;
    feed_w(2, 0, 1'b0);
    wait_idle();
    n_cmp = n_cmp + 1;
    if (n_fm_wr - fm0 != 0 || init_fm_data_done !== 1'b1 || weight_data_done !== 1'b1 || w_q.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL zero_fm: got fm_writes=%0d fm_done=%b w_done=%b, required 0/1/1",
               n_fm_wr - fm0, init_fm_data_done, weight_data_done);
    end
  endtask

  task automatic test_reset_mid();
    start_init(18, 4);
    feed_fm(5, 1'b0);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    n_cmp = n_cmp + 1;
    if ({fm_wr_en, w_wr_en, fm_src_ready, init_fm_data_done, weight_data_done, busy} !== 6'b0 ||
        fm_wr_addr !== 10'd0 || fm_wr_data !== '0) begin
      n_err = n_err + 1;
      $display("FAIL reset_mid: got flags=%b fm_addr=%0d, required 000000 and 0",
               {fm_wr_en, w_wr_en, fm_src_ready, init_fm_data_done, weight_data_done, busy}, fm_wr_addr);
    end
    n_cmp = n_cmp + 1;
    if (fm_q.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL reset_mid_pending: got %0d writes outstanding, required 0", fm_q.size());
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    start_init(3, 1);
    feed_fm(3, 1'b0);
    feed_w(1, 0, 1'b0);
    wait_idle();
    n_cmp = n_cmp + 1;
    if (fm_q.size() != 0 || w_q.size() != 0 || init_fm_data_done !== 1'b1 || weight_data_done !== 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL reset_restart: got pending=%0d/%0d done=%b%b, required 0/0 and 11",
               fm_q.size(), w_q.size(), init_fm_data_done, weight_data_done);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_update();
    test_gaps();
    test_collision();
    test_zero_fm();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
